// File: rtl/fpu_bus_ctrl.sv
// Byte-wide bus front end for the fpu. It assembles the operands and op code, launches a
// command with a held start, captures the result, and reports status, IRQ and timeouts.
module fpu_bus_ctrl #(
  parameter int unsigned OP_W           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TMO_W          = 13
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            cs,
  input  logic            wr,
  input  logic            rd,
  input  logic [3:0]      addr,
  input  logic [7:0]      data_in,
  output logic [7:0]      data_out,
  output logic [31:0]     fpu_a,
  output logic [31:0]     fpu_b,
  output logic [OP_W-1:0] fpu_op,
  output logic            fpu_start,
  input  logic [31:0]     fpu_result,
  input  logic            fpu_cmd_end,
  input  logic            fpu_busy,
  output logic            irq
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  state_e           state_q, state_d;
  logic [31:0]      a_q, b_q, result_q;
  logic [OP_W-1:0]  op_q;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             start_q, start_d;
  logic             cmd_end_q;
  logic             done_q, err_busy_q, err_tmo_q, irq_en_q;
  logic [7:0]       data_out_q, rdata;

  logic wr_en, rd_en, idle, op_wr, cfg_wr, busy_wr, cmd_wr, stat_wr;
  logic cmd_end_rise, tmo_hit, complete, abort;

  assign wr_en   = cs & wr;
  assign rd_en   = cs & rd;
  assign idle    = (state_q == StIdle);
  // Addresses 0..9 hold command state and are frozen while a command is in flight.
  assign op_wr   = wr_en & (addr <= 4'd9);
  assign cfg_wr  = op_wr & idle;
  assign busy_wr = op_wr & ~idle;
  assign cmd_wr  = cfg_wr & (addr == 4'd9);
  assign stat_wr = wr_en & (addr == 4'd10);

  assign cmd_end_rise = fpu_cmd_end & ~cmd_end_q;
  assign tmo_hit      = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cmd_wr) state_d = StLaunch;
      StLaunch: state_d = StWait;
      StWait:   if (cmd_end_rise || tmo_hit) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output / control logic; completion takes priority over timeout
  always_comb begin
    start_d  = start_q;
    tmo_d    = tmo_q;
    complete = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      StIdle:   start_d = 1'b0;
      StLaunch: begin
        start_d = 1'b1;
        tmo_d   = '0;
      end
      StWait: begin
        if (cmd_end_rise) begin
          complete = 1'b1;
          start_d  = 1'b0;
        end else if (tmo_hit) begin
          abort   = 1'b1;
          start_d = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default:  start_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      start_q   <= 1'b0;
      tmo_q     <= '0;
      cmd_end_q <= 1'b0;
    end else begin
      start_q   <= start_d;
      tmo_q     <= tmo_d;
      cmd_end_q <= fpu_cmd_end;
    end
  end

  // Operand and op-code registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (cfg_wr) begin
      unique case (addr[3:2])
        2'd0:    a_q[{addr[1:0], 3'b000} +: 8] <= data_in;
        2'd1:    b_q[{addr[1:0], 3'b000} +: 8] <= data_in;
        default: if (addr == 4'd8) op_q <= data_in[OP_W-1:0];
      endcase
    end
  end

  // Status and result; a completion set beats a same-cycle W1C clear
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      result_q   <= '0;
      done_q     <= 1'b0;
      err_busy_q <= 1'b0;
      err_tmo_q  <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      if (complete) result_q <= fpu_result;

      if (complete)                      done_q <= 1'b1;
      else if (cmd_wr)                   done_q <= 1'b0;
      else if (stat_wr && data_in[1])    done_q <= 1'b0;

      if (busy_wr)                       err_busy_q <= 1'b1;
      else if (stat_wr && data_in[2])    err_busy_q <= 1'b0;

      if (abort)                         err_tmo_q <= 1'b1;
      else if (stat_wr && data_in[3])    err_tmo_q <= 1'b0;

      if (stat_wr)                       irq_en_q <= data_in[4];
    end
  end

  // Read mux
  always_comb begin
    rdata = 8'h00;
    unique case (addr[3:2])
      2'd0: rdata = a_q[{addr[1:0], 3'b000} +: 8];
      2'd1: rdata = b_q[{addr[1:0], 3'b000} +: 8];
      2'd2: begin
        unique case (addr[1:0])
          2'd0:    rdata = 8'(op_q);
          2'd2:    rdata = {3'b000, irq_en_q, err_tmo_q, err_busy_q, done_q, ~idle | fpu_busy};
          default: rdata = 8'h00;
        endcase
      end
      default: rdata = result_q[{addr[1:0], 3'b000} +: 8];
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst)       data_out_q <= 8'h00;
    else if (rd_en) data_out_q <= rdata;
  end

  assign data_out  = data_out_q;
  assign fpu_a     = a_q;
  assign fpu_b     = b_q;
  assign fpu_op    = op_q;
  assign fpu_start = start_q;
  assign irq       = done_q & irq_en_q;

endmodule

// File: tb/tb_fpu_bus_ctrl.sv
// Directed bench for fpu_bus_ctrl; the fpu is stubbed by driving cmd_end/result by hand.
module tb_fpu_bus_ctrl;

  localparam int unsigned OP_W = 4;

  logic            clk = 1'b0;
  logic            arst;
  logic            cs, wr, rd;
  logic [3:0]      addr;
  logic [7:0]      data_in;
  logic [7:0]      data_out;
  logic [31:0]     fpu_a, fpu_b, fpu_result;
  logic [OP_W-1:0] fpu_op;
  logic            fpu_start, fpu_cmd_end, fpu_busy, irq;

  int checks   = 0;
  int failures = 0;

  fpu_bus_ctrl #(
    .OP_W          (OP_W),
    .TIMEOUT_CYCLES(16),
    .TMO_W         (5)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .cs         (cs),
    .wr         (wr),
    .rd         (rd),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_op     (fpu_op),
    .fpu_start  (fpu_start),
    .fpu_result (fpu_result),
    .fpu_cmd_end(fpu_cmd_end),
    .fpu_busy   (fpu_busy),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; data_in = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
    d = data_out;
  endtask

  task automatic load_operands(input logic [31:0] a, input logic [31:0] b,
                               input logic [7:0] op);
    for (int i = 0; i < 4; i++) bus_write(4'(i), a[8*i +: 8]);
    for (int i = 0; i < 4; i++) bus_write(4'(4 + i), b[8*i +: 8]);
    bus_write(4'd8, op);
  endtask

  // CMD write, then start must be low one edge later and high the edge after.
  task automatic start_cmd();
    bus_write(4'd9, 8'h00);
    checks++;
    if (fpu_start !== 1'b0) begin
      failures++; $display("FAIL launch_n1: fpu_start=%b expected 0", fpu_start);
    end
    @(posedge clk); #1;
    checks++;
    if (fpu_start !== 1'b1) begin
      failures++; $display("FAIL launch_n2: fpu_start=%b expected 1", fpu_start);
    end
  endtask

  // Wait, raise cmd_end with a result; start must drop on the next edge.
  task automatic finish_cmd(input int lat, input logic [31:0] res);
    repeat (lat) begin @(posedge clk); #1; end
    checks++;
    if (fpu_start !== 1'b1) begin
      failures++; $display("FAIL start_held: fpu_start=%b expected 1", fpu_start);
    end
    fpu_result = res; fpu_cmd_end = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (fpu_start !== 1'b0) begin
      failures++; $display("FAIL complete_start: fpu_start=%b expected 0", fpu_start);
    end
    fpu_cmd_end = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    checks++;
    if (data_out !== 8'h00 || fpu_start !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: data_out=%h start=%b irq=%b expected 00 0 0",
               data_out, fpu_start, irq);
    end
    for (int i = 0; i < 16; i++) begin
      bus_read(4'(i), d);
      checks++;
      if (d !== 8'h00) begin
        failures++; $display("FAIL reset_read addr %0d: got %h expected 00", i, d);
      end
    end
    fpu_busy = 1'b1;
    bus_read(4'd10, d);
    fpu_busy = 1'b0;
    checks++;
    if (d !== 8'h01) begin
      failures++; $display("FAIL fpu_busy_status: got %h expected 01", d);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    logic [7:0] exp_res [4];
    exp_res = '{8'h00, 8'h00, 8'h00, 8'h3e};
    load_operands(32'h3e80_0000, 32'h3f00_0000, 8'h03);
    checks++;
    if (fpu_a !== 32'h3e80_0000 || fpu_b !== 32'h3f00_0000 || fpu_op !== 4'h3) begin
      failures++;
      $display("FAIL operands: a=%h b=%h op=%h expected 3e800000 3f000000 3",
               fpu_a, fpu_b, fpu_op);
    end
    start_cmd();
    bus_read(4'd10, d);
    checks++;
    if (d !== 8'h01) begin
      failures++; $display("FAIL status_wait: got %h expected 01", d);
    end
    finish_cmd(9, 32'h3e00_0000);
    for (int i = 0; i < 4; i++) begin
      bus_read(4'(12 + i), d);
      checks++;
      if (d !== exp_res[i]) begin
        failures++; $display("FAIL result_byte %0d: got %h expected %h", i, d, exp_res[i]);
      end
    end
    bus_read(4'd10, d);
    checks++;
    if (d !== 8'h02) begin
      failures++; $display("FAIL status_done: got %h expected 02", d);
    end
    bus_write(4'd11, 8'h55);
    checks++;
    if (data_out !== 8'h02 || irq !== 1'b0) begin
      failures++; $display("FAIL data_out_hold: data_out=%h irq=%b expected 02 0", data_out, irq);
    end
  endtask

  task automatic test_irq();
    logic [7:0] d;
    bus_write(4'd10, 8'h02);
    bus_write(4'd10, 8'h10);
    bus_read(4'd10, d);
    checks++;
    if (d !== 8'h10 || irq !== 1'b0) begin
      failures++; $display("FAIL irq_en_set: status=%h irq=%b expected 10 0", d, irq);
    end
    start_cmd();
    finish_cmd(5, 32'h3f80_0000);
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL irq_rise: irq=%b expected 1", irq);
    end
    bus_write(4'd10, 8'h12);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_clear: irq=%b expected 0", irq);
    end
    bus_read(4'd10, d);
    checks++;
    if (d !== 8'h10) begin
      failures++; $display("FAIL irq_en_kept: status=%h expected 10", d);
    end
  endtask

  task automatic test_busy_err();
    logic [7:0] d;
    start_cmd();
    bus_write(4'd0, 8'hff);
    checks++;
    if (fpu_a !== 32'h3e80_0000) begin
      failures++; $display("FAIL busy_write_a: fpu_a=%h expected 3e800000", fpu_a);
    end
    bus_write(4'd9, 8'h00);
    bus_read(4'd10, d);
    checks++;
    if (d !== 8'h15) begin
      failures++; $display("FAIL err_busy_status: got %h expected 15", d);
    end
    finish_cmd(3, 32'h4049_0fdb);
    bus_read(4'd15, d);
    checks++;
    if (d !== 8'h40) begin
      failures++; $display("FAIL busy_result: got %h expected 40", d);
    end
    bus_read(4'd10, d);
    checks++;
    if (d !== 8'h16 || irq !== 1'b1) begin
      failures++; $display("FAIL busy_done_status: status=%h irq=%b expected 16 1", d, irq);
    end
    bus_write(4'd10, 8'h16);
    bus_read(4'd10, d);
    checks++;
    if (d !== 8'h10) begin
      failures++; $display("FAIL w1c_clear: got %h expected 10", d);
    end
  endtask

  task automatic test_stale_cmd_end();
    logic [7:0] d;
    fpu_cmd_end = 1'b1;
    @(posedge clk); #1;
    start_cmd();
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (fpu_start !== 1'b1) begin
      failures++; $display("FAIL stale_no_edge: fpu_start=%b expected 1", fpu_start);
    end
    fpu_cmd_end = 1'b0;
    @(posedge clk); #1;
    finish_cmd(1, 32'hc000_0000);
    bus_read(4'd15, d);
    checks++;
    if (d !== 8'hc0) begin
      failures++; $display("FAIL stale_result: got %h expected c0", d);
    end
    bus_write(4'd10, 8'h12);
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    start_cmd();
    repeat (15) begin @(posedge clk); #1; end
    checks++;
    if (fpu_start !== 1'b1) begin
      failures++; $display("FAIL tmo_before: fpu_start=%b expected 1", fpu_start);
    end
    @(posedge clk); #1;
    checks++;
    if (fpu_start !== 1'b0) begin
      failures++; $display("FAIL tmo_drop: fpu_start=%b expected 0", fpu_start);
    end
    bus_read(4'd10, d);
    checks++;
    if (d !== 8'h18 || irq !== 1'b0) begin
      failures++; $display("FAIL tmo_status: status=%h irq=%b expected 18 0", d, irq);
    end
    bus_read(4'd15, d);
    checks++;
    if (d !== 8'hc0) begin
      failures++; $display("FAIL tmo_result_kept: got %h expected c0", d);
    end
    bus_write(4'd10, 8'h18);
    bus_read(4'd10, d);
    checks++;
    if (d !== 8'h10) begin
      failures++; $display("FAIL tmo_clear: got %h expected 10", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    start_cmd();
    repeat (3) begin @(posedge clk); #1; end
    arst = 1'b1;
    #1;
    checks++;
    if (fpu_start !== 1'b0 || fpu_a !== 32'h0 || irq !== 1'b0 || data_out !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: start=%b a=%h irq=%b data_out=%h expected 0 0 0 00",
               fpu_start, fpu_a, irq, data_out);
    end
    #2 arst = 1'b0;
    bus_read(4'd10, d);
    checks++;
    if (d !== 8'h00) begin
      failures++; $display("FAIL reset_status: got %h expected 00", d);
    end
    load_operands(32'h3f80_0000, 32'h4000_0000, 8'h01);
    start_cmd();
    finish_cmd(4, 32'h1234_5678);
    bus_read(4'd12, d);
    checks++;
    if (d !== 8'h78) begin
      failures++; $display("FAIL post_reset_result: got %h expected 78", d);
    end
    bus_read(4'd10, d);
    checks++;
    if (d !== 8'h02) begin
      failures++; $display("FAIL post_reset_status: got %h expected 02", d);
    end
  endtask

  initial begin
    arst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 4'd0; data_in = 8'h00;
    fpu_result = 32'h0; fpu_cmd_end = 1'b0; fpu_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    test_reset();
    test_basic();
    test_irq();
    test_busy_err();
    test_stale_cmd_end();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
